// File: rtl/m_similarity_window_sequencer_pkg.sv
// Shared definitions for the 3x3 similarity window sequencer.
//   state_t        : frame controller states
//   TAP_*          : index of each window tap, row-major NW..SE, centre at TAP_FIJ
//   STAGE_LATENCY  : cycles from pixel acceptance to the stage's registered result
//   centre_t       : one emitted centre travelling down the alignment pipeline
package m_similarity_window_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int unsigned TAP_A    = 0;
    localparam int unsigned TAP_B    = 1;
    localparam int unsigned TAP_C    = 2;
    localparam int unsigned TAP_D    = 3;
    localparam int unsigned TAP_FIJ  = 4;
    localparam int unsigned TAP_E    = 5;
    localparam int unsigned TAP_F    = 6;
    localparam int unsigned TAP_G    = 7;
    localparam int unsigned TAP_H    = 8;
    localparam int unsigned NUM_TAPS = 9;

    localparam int unsigned STAGE_LATENCY = 2;

    typedef struct packed {
        logic       valid;
        logic       interior;
        logic       last;
        logic [7:0] pix;
    } centre_t;

endpackage

// File: rtl/m_similarity_window_sequencer_line_buffer.sv
// m_line_buffer: pWidth-deep circular delay line for 8-bit pixels.
//   iClk, iRst : clock, asynchronous active-high reset (pointer only)
//   iEn        : advance one position (write iv8Din, move pointer)
//   iv8Din     : sample written at the current pointer
//   ov8Dout    : sample written pWidth advances ago (read before write)
module m_line_buffer #(
    parameter int pWidth = 640
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEn,
    input  logic [7:0] iv8Din,
    output logic [7:0] ov8Dout
);

    localparam int unsigned AW = $clog2(pWidth);
    localparam logic [AW-1:0] LAST = AW'(pWidth - 1);

    logic [7:0]    mem_q [pWidth];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    assign ptr_d   = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    assign ov8Dout = mem_q[ptr_q];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ptr_q <= '0;
        end else if (iEn) begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge iClk) begin
        if (iEn) begin
            mem_q[ptr_q] <= iv8Din;
        end
    end

endmodule

// File: rtl/m_similarity_window_sequencer.sv
// Raster-scan front end for the 3x3 similarity/decision stage.
//   iStart/iPixelValid/iv8Pixel : frame start and raster pixel input
//   ov8Pixel_a.._h, _fij        : 3x3 window taps (held when oDataValid=0)
//   oDataValid/oEn              : stage data-valid and enable strobes
//   oCenterValid/oBypass        : centre due this cycle; 1 = border, use ov8BypassPixel
//   oBusy/oFrameDone/oProtoErr  : status, end-of-frame pulse, sticky protocol error
module m_similarity_window_sequencer
    import m_similarity_window_sequencer_pkg::*;
#(
    parameter int pWidth  = 640,
    parameter int pHeight = 480,
    parameter int pCntW   = 12
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic       iPixelValid,
    input  logic [7:0] iv8Pixel,
    output logic [7:0] ov8Pixel_a,
    output logic [7:0] ov8Pixel_b,
    output logic [7:0] ov8Pixel_c,
    output logic [7:0] ov8Pixel_d,
    output logic [7:0] ov8Pixel_fij,
    output logic [7:0] ov8Pixel_e,
    output logic [7:0] ov8Pixel_f,
    output logic [7:0] ov8Pixel_g,
    output logic [7:0] ov8Pixel_h,
    output logic       oDataValid,
    output logic       oEn,
    output logic       oCenterValid,
    output logic       oBypass,
    output logic [7:0] ov8BypassPixel,
    output logic       oBusy,
    output logic       oFrameDone,
    output logic       oProtoErr
);

    localparam logic [pCntW-1:0] C_ONE     = pCntW'(1);
    localparam logic [pCntW-1:0] C_TWO     = pCntW'(2);
    localparam logic [pCntW-1:0] LAST_COL  = pCntW'(pWidth - 1);
    localparam logic [pCntW-1:0] LAST_ROW  = pCntW'(pHeight - 1);
    localparam logic [pCntW-1:0] FLUSH_END = pCntW'(pWidth);

    state_t           state_q, state_d;
    logic [pCntW-1:0] row_q, row_d;
    logic [pCntW-1:0] col_q, col_d;
    logic             err_q, err_d;
    logic             done_q;
    logic [7:0]       win_q  [3][2];   // [row r-2..r][older, newer column]
    logic [7:0]       taps_q [NUM_TAPS];
    logic [7:0]       taps_d [NUM_TAPS];
    centre_t          pipe_q [STAGE_LATENCY];
    centre_t          centre_d;
    logic [7:0]       lb1_dout, lb2_dout;
    logic             in_frame, accept, advance;

    assign in_frame = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign accept   = iPixelValid && in_frame;
    // FLUSH keeps the delay lines moving so the last row drains out of lb1.
    assign advance  = accept || (state_q == ST_FLUSH);

    m_line_buffer #(.pWidth(pWidth)) u_lb1 (
        .iClk(iClk), .iRst(iRst), .iEn(advance), .iv8Din(iv8Pixel), .ov8Dout(lb1_dout)
    );
    m_line_buffer #(.pWidth(pWidth)) u_lb2 (
        .iClk(iClk), .iRst(iRst), .iEn(advance), .iv8Din(lb1_dout), .ov8Dout(lb2_dout)
    );

    // Window centred on the previous column of row r-1, completed by the incoming column.
    always_comb begin
        taps_d[TAP_A]   = win_q[0][0];
        taps_d[TAP_B]   = win_q[0][1];
        taps_d[TAP_C]   = lb2_dout;
        taps_d[TAP_D]   = win_q[1][0];
        taps_d[TAP_FIJ] = win_q[1][1];
        taps_d[TAP_E]   = lb1_dout;
        taps_d[TAP_F]   = win_q[2][0];
        taps_d[TAP_G]   = win_q[2][1];
        taps_d[TAP_H]   = iv8Pixel;
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        centre_d = '0;
        if (accept) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q != LAST_ROW) row_d = row_q + C_ONE;
            end else begin
                col_d = col_q + C_ONE;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_FILL;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_FILL: begin
                if (accept && row_q == C_ONE && col_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    // The centre emitted is always the newest row r-1 sample before the shift.
                    centre_d.valid    = (col_q != '0) || (row_q >= C_TWO);
                    centre_d.interior = (row_q >= C_TWO) && (col_q >= C_TWO);
                    centre_d.pix      = win_q[1][1];
                    if (row_q == LAST_ROW && col_q == LAST_COL) state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                centre_d.valid = 1'b1;
                centre_d.pix   = win_q[1][1];
                col_d          = col_q + C_ONE;
                if (col_q == FLUSH_END) begin
                    centre_d.last = 1'b1;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Error set has priority over the clear of an accepted start in the same cycle.
    assign err_d = ((iStart && state_q == ST_IDLE) ? 1'b0 : err_q)
                 | (iPixelValid && !in_frame)
                 | (iStart && state_q != ST_IDLE);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                win_q[i][0] <= '0;
                win_q[i][1] <= '0;
            end
            for (int unsigned i = 0; i < NUM_TAPS; i++) taps_q[i] <= '0;
            for (int unsigned i = 0; i < STAGE_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= err_d;
            done_q  <= pipe_q[STAGE_LATENCY-1].valid && pipe_q[STAGE_LATENCY-1].last;
            if (advance) begin
                for (int unsigned i = 0; i < 3; i++) win_q[i][0] <= win_q[i][1];
                win_q[0][1] <= lb2_dout;
                win_q[1][1] <= lb1_dout;
                win_q[2][1] <= iv8Pixel;
            end
            if (centre_d.valid && centre_d.interior) taps_q <= taps_d;
            pipe_q[0] <= centre_d;
            for (int unsigned i = 1; i < STAGE_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign ov8Pixel_a     = taps_q[TAP_A];
    assign ov8Pixel_b     = taps_q[TAP_B];
    assign ov8Pixel_c     = taps_q[TAP_C];
    assign ov8Pixel_d     = taps_q[TAP_D];
    assign ov8Pixel_fij   = taps_q[TAP_FIJ];
    assign ov8Pixel_e     = taps_q[TAP_E];
    assign ov8Pixel_f     = taps_q[TAP_F];
    assign ov8Pixel_g     = taps_q[TAP_G];
    assign ov8Pixel_h     = taps_q[TAP_H];
    assign oDataValid     = pipe_q[0].valid && pipe_q[0].interior;
    assign oEn            = pipe_q[1].valid && pipe_q[1].interior;
    assign oCenterValid   = pipe_q[STAGE_LATENCY-1].valid;
    assign oBypass        = pipe_q[STAGE_LATENCY-1].valid && !pipe_q[STAGE_LATENCY-1].interior;
    assign ov8BypassPixel = pipe_q[STAGE_LATENCY-1].pix;
    assign oBusy          = (state_q != ST_IDLE);
    assign oFrameDone     = done_q;
    assign oProtoErr      = err_q;

endmodule

// File: tb/tb_m_similarity_window_sequencer.sv
module tb_m_similarity_window_sequencer;

    localparam int W = 4;
    localparam int H = 3;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iStart = 1'b0;
    logic       iPixelValid = 1'b0;
    logic [7:0] iv8Pixel = '0;
    logic [7:0] ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij;
    logic [7:0] ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h, ov8BypassPixel;
    logic       oDataValid, oEn, oCenterValid, oBypass, oBusy, oFrameDone, oProtoErr;

    m_similarity_window_sequencer #(.pWidth(W), .pHeight(H), .pCntW(12)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iPixelValid(iPixelValid),
        .iv8Pixel(iv8Pixel),
        .ov8Pixel_a(ov8Pixel_a), .ov8Pixel_b(ov8Pixel_b), .ov8Pixel_c(ov8Pixel_c),
        .ov8Pixel_d(ov8Pixel_d), .ov8Pixel_fij(ov8Pixel_fij), .ov8Pixel_e(ov8Pixel_e),
        .ov8Pixel_f(ov8Pixel_f), .ov8Pixel_g(ov8Pixel_g), .ov8Pixel_h(ov8Pixel_h),
        .oDataValid(oDataValid), .oEn(oEn), .oCenterValid(oCenterValid),
        .oBypass(oBypass), .ov8BypassPixel(ov8BypassPixel), .oBusy(oBusy),
        .oFrameDone(oFrameDone), .oProtoErr(oProtoErr)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference frame and expected events keyed by the cycle they must appear in.
    logic [7:0]  pix [H][W];
    logic [71:0] exp_taps [int];
    logic [8:0]  exp_cv   [int];
    int          exp_done_cyc = -1;
    int          n_cv = 0;
    bit          mon_on = 1'b0;
    bit          exp_err = 1'b0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Centre (r,c) with its result due in cycle t.
    task automatic add_centre(input int r, input int c, input int t);
        if (r >= 1 && r <= H-2 && c >= 1 && c <= W-2) begin
            exp_taps[t-1] = {pix[r-1][c-1], pix[r-1][c], pix[r-1][c+1],
                             pix[r][c-1],   pix[r][c],   pix[r][c+1],
                             pix[r+1][c-1], pix[r+1][c], pix[r+1][c+1]};
            exp_cv[t] = {1'b0, pix[r][c]};
        end else begin
            exp_cv[t] = {1'b1, pix[r][c]};
        end
    endtask

    // Pixel (r,c) accepted in cycle n: which centres it completes.
    task automatic note_accept(input int r, input int c, input int n);
        if (r >= 1 && c >= 1) add_centre(r-1, c-1, n+2);
        if (r >= 2 && c == 0) add_centre(r-2, W-1, n+2);
        if (r == H-1 && c == W-1) begin
            add_centre(H-2, W-1, n+3);
            for (int k = 0; k < W; k++) add_centre(H-1, k, n+4+k);
            exp_done_cyc = n + 4 + W;
        end
    endtask

    always @(negedge iClk) begin
        if (mon_on) begin
            check("dv", 72'(oDataValid), 72'(exp_taps.exists(cyc)));
            if (oDataValid && exp_taps.exists(cyc))
                check("taps", {ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
                               ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h}, exp_taps[cyc]);
            check("en", 72'(oEn), 72'(exp_taps.exists(cyc-1)));
            check("cv", 72'(oCenterValid), 72'(exp_cv.exists(cyc)));
            if (oCenterValid && exp_cv.exists(cyc)) begin
                n_cv++;
                check("bypass", 72'(oBypass), 72'(exp_cv[cyc][8]));
                if (exp_cv[cyc][8]) check("bpix", 72'(ov8BypassPixel), 72'(exp_cv[cyc][7:0]));
            end
            check("done", 72'(oFrameDone), 72'(cyc == exp_done_cyc));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_taps"}, {ov8Pixel_a, ov8Pixel_b, ov8Pixel_c, ov8Pixel_d, ov8Pixel_fij,
                               ov8Pixel_e, ov8Pixel_f, ov8Pixel_g, ov8Pixel_h}, 72'd0);
        check({tag, "_ctl"}, 72'({ov8BypassPixel, oDataValid, oEn, oCenterValid, oBypass,
                                  oBusy, oFrameDone, oProtoErr}), 72'd0);
    endtask

    // kind: 0 constant 100, 1 ramp 10*r+c, 2 random. gaps: 0 none, 1 alternate, 2 random.
    task automatic run_frame(input int kind, input int gaps, input bit start_pix,
                             input bit inject, input int abort_at);
        int r, c, g;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                pix[i][j] = (kind == 0) ? 8'd100 :
                            (kind == 1) ? 8'(10*i + j) : 8'($urandom_range(0, 255));
        n_cv = 0;
        @(posedge iClk); #1;
        iStart = 1'b1; iPixelValid = start_pix; iv8Pixel = 8'hEE;
        @(posedge iClk); #1;
        iStart = 1'b0; iPixelValid = 1'b0;
        exp_err = start_pix;
        check("err_at_start", 72'(oProtoErr), 72'(exp_err));
        check("busy_at_start", 72'(oBusy), 72'd1);
        for (int i = 0; i < W*H; i++) begin
            r = i / W;
            c = i % W;
            if (i == abort_at) begin
                mon_on = 1'b0;
                iPixelValid = 1'b0;
                #2 iRst = 1'b1;
                #1 check_all_zero("abort");
                exp_taps.delete();
                exp_cv.delete();
                exp_done_cyc = -1;
                repeat (2) @(posedge iClk);
                #1 iRst = 1'b0;
                @(posedge iClk); #1;
                mon_on = 1'b1;
                return;
            end
            g = (gaps == 0) ? 0 : (gaps == 1) ? 1 : int'($urandom_range(0, 2));
            repeat (g) begin
                iPixelValid = 1'b0;
                @(posedge iClk); #1;
            end
            iPixelValid = 1'b1;
            iv8Pixel = pix[r][c];
            iStart = inject && (i == 6);
            if (inject && i == 6) exp_err = 1'b1;
            note_accept(r, c, cyc);
            @(posedge iClk); #1;
            iStart = 1'b0;
        end
        // First FLUSH cycle: a pixel here must be dropped.
        iPixelValid = inject;
        iv8Pixel = 8'h55;
        if (inject) exp_err = 1'b1;
        @(posedge iClk); #1;
        iPixelValid = 1'b0;
        for (int k = 0; k < 50 && cyc < exp_done_cyc; k++) begin
            @(posedge iClk); #1;
        end
        check("centres", 72'(n_cv), 72'(W*H));
        check("busy_end", 72'(oBusy), 72'd0);
        check("err_end", 72'(oProtoErr), 72'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 iRst = 1'b1;
        repeat (3) @(posedge iClk);
        #1 check_all_zero("reset");
        iRst = 1'b0;
        @(posedge iClk); #1;
        mon_on = 1'b1;

        run_frame(0, 0, 1'b0, 1'b0, -1);
        repeat (3) begin @(posedge iClk); #1; end
        run_frame(1, 0, 1'b0, 1'b0, -1);
        run_frame(1, 1, 1'b0, 1'b0, -1);
        run_frame(1, 0, 1'b0, 1'b1, -1);
        run_frame(1, 0, 1'b0, 1'b0, -1);
        run_frame(1, 0, 1'b0, 1'b0, 7);
        run_frame(1, 0, 1'b0, 1'b0, -1);
        run_frame(1, 0, 1'b0, 1'b0, -1);
        run_frame(1, 0, 1'b1, 1'b0, -1);
        for (int n = 0; n < 6; n++)
            run_frame(2, 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        repeat (4) begin @(posedge iClk); #1; end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
